t03_icache_fill_controller: RTL and testbench
=============================================

Name: t03_icache_fill_controller

Overview:
Fetch-side fill engine for the team's direct-mapped instruction cache. It serves CPU fetches from the cache on a hit. On a miss it runs a single-word read handshake to instruction memory, then writes the returned word into the cache.
- Drives the cache's `cache_read`, fill data and lookup address.
- Uses the cache's `next_hit` to prefetch the next PC while idle.
- Sits between the CPU fetch stage, the cache, and the memory/bus arbiter.

Parameters:
TIMEOUT_CYCLES, 64, max cycles `mem_read` is held without `mem_ack` before the request is abandoned
PREFETCH_EN, 1, 1 = prefetch `next_pc` on predicted miss; 0 = demand fetch only
CNT_W, 7, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
pc  in  32  current fetch address from CPU
next_pc  in  32  predicted next fetch address
fetch_req  in  1  CPU requests instruction at `pc`
instr_out  out  32  instruction to CPU
instr_valid  out  1  `instr_out` valid this cycle
stall  out  1  CPU must hold `pc`/`fetch_req`
fetch_error  out  1  one-cycle pulse: demand fetch timed out
cache_addr  out  32  to cache `current_address`
cache_next_addr  out  32  to cache `next_address` (= `next_pc`)
cache_out  in  32  cache data
cache_hit  in  1  cache hit for `cache_addr`
cache_next_hit  in  1  cache hit for `cache_next_addr`
cache_fill  out  1  to cache `cache_read`
fill_instruction  out  32  to cache `input_instruction`
mem_read  out  1  memory read request
mem_addr  out  32  word-aligned read address
mem_rdata  in  32  memory data, valid when `mem_ack`
mem_ack  in  1  one-cycle completion strobe

Behaviour:
- **Reset (async):** state IDLE; every output 0 except `cache_addr` = `pc` and `cache_next_addr` = `next_pc`.
- **States:**
  - IDLE
  - D_WAIT (demand request outstanding)
  - D_FILL (demand fill and deliver)
  - P_WAIT (prefetch outstanding)
  - P_FILL (prefetch fill)
- **Cache address mux:**
  - D_FILL: latched `miss_addr`.
  - P_FILL: latched `pf_addr`.
  - Otherwise: `pc`.
- **IDLE, `fetch_req` and `cache_hit`:**
  - `instr_out` = `cache_out`, `instr_valid` = 1, `stall` = 0 in the same cycle (zero latency).
- **IDLE, `fetch_req` and not `cache_hit`:**
  - `stall` = 1 combinationally.
  - Latch `miss_addr` = {`pc[31:2]`, 2'b00}; go D_WAIT next edge.
- **IDLE, no demand miss, PREFETCH_EN, not `cache_next_hit`, `next_pc[31:2]` != `pc[31:2]`:**
  - Latch `pf_addr` = {`next_pc[31:2]`, 2'b00}; go P_WAIT.
  - A demand miss has priority over a prefetch in the same cycle.
- **D_WAIT / P_WAIT:**
  - `mem_read` = 1; `mem_addr` = latched address, held stable until `mem_ack`.
  - On `mem_ack`: latch `mem_rdata` into `fill_buf`, reset the timeout counter, go D_FILL / P_FILL.
  - `mem_read` drops the cycle after `mem_ack`; it is never asserted in a FILL state.
- **Timeout counter:**
  - Increments each WAIT cycle without `mem_ack`.
  - Reaching TIMEOUT_CYCLES: drop `mem_read`, return to IDLE.
  - Demand timeout: `fetch_error` = 1 for one cycle; `stall` drops that cycle; `instr_valid` = 0.
  - Prefetch timeout: silent.
- **D_FILL (one cycle):**
  - `cache_fill` = 1, `fill_instruction` = `fill_buf`.
  - `instr_out` = `fill_buf`, `instr_valid` = 1, `stall` = 0.
  - Next state IDLE. Miss-to-delivery latency = memory latency + 2 cycles.
- **Zero-word rule:** the cache does not latch an all-zero fill word. The controller still delivers a zero word to the CPU from `fill_buf`, so correctness never depends on the cache storing it. Every fetch of that address misses again; this is accepted.
- **P_FILL (one cycle):** `cache_fill` = 1 with `pf_addr`, then IDLE.
- **Demand during prefetch (P_WAIT / P_FILL, `fetch_req` asserted):**
  - `stall` = 1.
  - If `pc[31:2]` == `pf_addr[31:2]`: in P_FILL, also `instr_out` = `fill_buf`, `instr_valid` = 1, `stall` = 0.
  - Otherwise: after P_FILL, IDLE re-evaluates the demand fetch normally.
- **PC stability:** the CPU holds `pc` while `stall` = 1. The controller uses only latched addresses once in a WAIT state, so a `pc` change mid-miss has no effect on the outstanding request.
- **Reset mid-operation:** the request is abandoned immediately, `mem_read` = 0, and no fill is written. A late `mem_ack` arriving in IDLE is ignored.
- At most one outstanding memory request at any time.

Decomposition:
- Shared package: state enum (IDLE, D_WAIT, D_FILL, P_WAIT, P_FILL) and the `WORD_ALIGN` mask constant.
- One sub-module, `t03_fetch_timeout`: counter with clear, enable and `expired`, sized by CNT_W / TIMEOUT_CYCLES.

Test Plan:
- **Hit:** `pc` = 0x40, cache holds 0x00A00093, `fetch_req` = 1 → same cycle `instr_out` = 0x00A00093, `instr_valid` = 1, `stall` = 0, `mem_read` = 0.
- **Miss, ack after 3 cycles:** `pc` = 0x104, memory returns 0x00112023 → `mem_addr` = 0x104 for 3 cycles; D_FILL asserts `cache_fill` and `instr_valid` with 0x00112023; refetch of 0x104 hits.
- **Zero word:** miss at 0x200, memory returns 0 → `instr_valid` with `instr_out` = 0; refetch of 0x200 misses again and reissues `mem_read`.
- **Prefetch:** idle, `next_pc` = 0x108 not cached → `mem_read` at 0x108. A demand for 0x108 during P_WAIT stalls, then is delivered in P_FILL.
- **Timeout:** miss at 0x300, no `mem_ack` → `mem_read` high for exactly 64 cycles, then `fetch_error` pulse, `stall` low, no `cache_fill`.
- **Reset mid-fetch:** assert `rst` in D_WAIT → `mem_read` low asynchronously. An `mem_ack` after reset produces no `cache_fill` and no `instr_valid`.

Source files
------------

// File: rtl/t03_icache_fill_controller_pkg.sv
// Shared types and constants for the instruction-cache fill controller.
// The state encoding is exported so checkers can bind to the debug port.
package t03_icache_fill_controller_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      D_WAIT = 3'd1,
      D_FILL = 3'd2,
      P_WAIT = 3'd3,
      P_FILL = 3'd4
   } fill_state_t;

   localparam logic [31:0] WORD_ALIGN = 32'hFFFF_FFFC;

endpackage

// File: rtl/t03_fetch_timeout.sv
// Wait-cycle counter for an outstanding memory read. Clear has priority,
// and the count holds at TIMEOUT_CYCLES once expired.
module t03_fetch_timeout #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] count;

   assign expired = (count == LIMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en && !expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/t03_icache_fill_controller.sv
// Fetch-side fill engine: serves hits from the direct-mapped I-cache, fills
// demand misses and next-PC prefetches with single-word memory reads.
module t03_icache_fill_controller
   import t03_icache_fill_controller_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int PREFETCH_EN    = 1,
   parameter int CNT_W          = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       pc,
   input  logic [31:0]       next_pc,
   input  logic              fetch_req,
   output logic [31:0]       instr_out,
   output logic              instr_valid,
   output logic              stall,
   output logic              fetch_error,
   output logic [31:0]       cache_addr,
   output logic [31:0]       cache_next_addr,
   input  logic [31:0]       cache_out,
   input  logic              cache_hit,
   input  logic              cache_next_hit,
   output logic              cache_fill,
   output logic [31:0]       fill_instruction,
   output logic              mem_read,
   output logic [31:0]       mem_addr,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output fill_state_t       state_dbg
);

   // Memory handshake: mem_read/mem_addr stay asserted and stable from the
   // first WAIT cycle until the cycle mem_ack is seen (or the timeout fires);
   // mem_ack is a single-cycle strobe and is only honoured in a WAIT state.

   fill_state_t state, state_nxt;
   logic [31:0] miss_addr, pf_addr, fill_buf;
   logic        miss_latch, pf_latch, buf_latch;
   logic        in_wait, expired;

   assign state_dbg       = state;
   assign cache_next_addr = next_pc;
   assign in_wait         = (state == D_WAIT) || (state == P_WAIT);

   t03_fetch_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (!in_wait || mem_ack),
      .en      (in_wait && !mem_ack),
      .expired (expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         miss_addr <= '0;
         pf_addr   <= '0;
         fill_buf  <= '0;
      end else begin
         state <= state_nxt;
         if (miss_latch) miss_addr <= pc & WORD_ALIGN;
         if (pf_latch)   pf_addr   <= next_pc & WORD_ALIGN;
         if (buf_latch)  fill_buf  <= mem_rdata;
      end
   end

   always_comb begin
      state_nxt        = state;
      instr_out        = '0;
      instr_valid      = 1'b0;
      stall            = 1'b0;
      fetch_error      = 1'b0;
      cache_addr       = pc;
      cache_fill       = 1'b0;
      fill_instruction = '0;
      mem_read         = 1'b0;
      mem_addr         = '0;
      miss_latch       = 1'b0;
      pf_latch         = 1'b0;
      buf_latch        = 1'b0;

      case (state)
         IDLE: begin
            if (fetch_req && cache_hit) begin
               instr_out   = cache_out;
               instr_valid = 1'b1;
            end
            // A demand miss wins over a prefetch launched in the same cycle.
            if (fetch_req && !cache_hit) begin
               stall      = 1'b1;
               miss_latch = 1'b1;
               state_nxt  = D_WAIT;
            end else if ((PREFETCH_EN != 0) && !cache_next_hit &&
                         (next_pc[31:2] != pc[31:2])) begin
               pf_latch  = 1'b1;
               state_nxt = P_WAIT;
            end
         end

         D_WAIT: begin
            if (expired) begin
               fetch_error = 1'b1;
               state_nxt   = IDLE;
            end else begin
               mem_read = 1'b1;
               mem_addr = miss_addr;
               stall    = 1'b1;
               if (mem_ack) begin
                  buf_latch = 1'b1;
                  state_nxt = D_FILL;
               end
            end
         end

         D_FILL: begin
            // Delivered from fill_buf, so a zero word the cache refuses to
            // store still reaches the CPU correctly.
            cache_addr       = miss_addr;
            cache_fill       = 1'b1;
            fill_instruction = fill_buf;
            instr_out        = fill_buf;
            instr_valid      = 1'b1;
            state_nxt        = IDLE;
         end

         P_WAIT: begin
            stall = fetch_req;
            if (expired) begin
               state_nxt = IDLE;
            end else begin
               mem_read = 1'b1;
               mem_addr = pf_addr;
               if (mem_ack) begin
                  buf_latch = 1'b1;
                  state_nxt = P_FILL;
               end
            end
         end

         P_FILL: begin
            cache_addr       = pf_addr;
            cache_fill       = 1'b1;
            fill_instruction = fill_buf;
            if (fetch_req) begin
               if (pc[31:2] == pf_addr[31:2]) begin
                  instr_out   = fill_buf;
                  instr_valid = 1'b1;
               end else begin
                  stall = 1'b1;
               end
            end
            state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase

      // While reset is held nothing may leak out of the IDLE hit path.
      if (rst) begin
         state_nxt        = IDLE;
         instr_out        = '0;
         instr_valid      = 1'b0;
         stall            = 1'b0;
         fetch_error      = 1'b0;
         cache_addr       = pc;
         cache_fill       = 1'b0;
         fill_instruction = '0;
         mem_read         = 1'b0;
         mem_addr         = '0;
         miss_latch       = 1'b0;
         pf_latch         = 1'b0;
         buf_latch        = 1'b0;
      end
   end

endmodule

// File: tb/tb_t03_icache_fill_controller.sv
// Directed bench for the I-cache fill controller with a behavioural
// direct-mapped cache (zero words never stored) and a hand-driven memory.
module tb_t03_icache_fill_controller;
   import t03_icache_fill_controller_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc, next_pc;
   logic        fetch_req;
   logic [31:0] instr_out;
   logic        instr_valid, stall, fetch_error;
   logic [31:0] cache_addr, cache_next_addr, cache_out;
   logic        cache_hit, cache_next_hit, cache_fill;
   logic [31:0] fill_instruction;
   logic        mem_read;
   logic [31:0] mem_addr, mem_rdata;
   logic        mem_ack;
   fill_state_t state_dbg;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   t03_icache_fill_controller dut (
      .clk              (clk),
      .rst              (rst),
      .pc               (pc),
      .next_pc          (next_pc),
      .fetch_req        (fetch_req),
      .instr_out        (instr_out),
      .instr_valid      (instr_valid),
      .stall            (stall),
      .fetch_error      (fetch_error),
      .cache_addr       (cache_addr),
      .cache_next_addr  (cache_next_addr),
      .cache_out        (cache_out),
      .cache_hit        (cache_hit),
      .cache_next_hit   (cache_next_hit),
      .cache_fill       (cache_fill),
      .fill_instruction (fill_instruction),
      .mem_read         (mem_read),
      .mem_addr         (mem_addr),
      .mem_rdata        (mem_rdata),
      .mem_ack          (mem_ack),
      .state_dbg        (state_dbg)
   );

   // ---------------- behavioural cache ----------------
   logic [31:0] cm_data  [16];
   logic [25:0] cm_tag   [16];
   logic        cm_valid [16];
   logic        cm_clr, pre_we;
   logic [31:0] pre_addr, pre_data;

   assign cache_hit      = cm_valid[cache_addr[5:2]] && (cm_tag[cache_addr[5:2]] == cache_addr[31:6]);
   assign cache_out      = cm_data[cache_addr[5:2]];
   assign cache_next_hit = cm_valid[cache_next_addr[5:2]] &&
                           (cm_tag[cache_next_addr[5:2]] == cache_next_addr[31:6]);

   always @(posedge clk) begin
      if (cm_clr) begin
         for (int i = 0; i < 16; i++) cm_valid[i] <= 1'b0;
      end else if (pre_we) begin
         cm_valid[pre_addr[5:2]] <= 1'b1;
         cm_tag[pre_addr[5:2]]   <= pre_addr[31:6];
         cm_data[pre_addr[5:2]]  <= pre_data;
      end else if (cache_fill && fill_instruction != 32'h0) begin
         cm_valid[cache_addr[5:2]] <= 1'b1;
         cm_tag[cache_addr[5:2]]   <= cache_addr[31:6];
         cm_data[cache_addr[5:2]]  <= fill_instruction;
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every delivered instruction must match the next expected word.
   always @(negedge clk) begin
      if (!rst && instr_valid) begin
         if (exp_q.size() == 0) check("valid_unexpected", {31'b0, instr_valid}, 32'h0);
         else                   check("deliver", instr_out, exp_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fetch(input logic [31:0] a, input logic [31:0] na, input logic req);
      pc        = a;
      next_pc   = na;
      fetch_req = req;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n_rd, n_fill;
      rst = 1'b1; cm_clr = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      set_fetch(32'h40, 32'h40, 1'b0);
      tick();
      cm_clr = 1'b0; pre_we = 1'b1; pre_addr = 32'h40; pre_data = 32'h00A00093;
      tick();
      pre_we = 1'b0;
      fetch_req = 1'b1;
      #1;
      check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
      check("rst_stall",       {31'b0, stall}, 32'h0);
      check("rst_mem_read",    {31'b0, mem_read}, 32'h0);
      check("rst_cache_addr",  cache_addr, 32'h40);
      check("rst_next_addr",   cache_next_addr, 32'h40);
      check("rst_instr_out",   instr_out, 32'h0);
      tick();
      rst = 1'b0;

      // Hit: zero-latency delivery.
      exp_q.push_back(32'h00A00093);
      #1;
      check("hit_instr_out",   instr_out, 32'h00A00093);
      check("hit_instr_valid", {31'b0, instr_valid}, 32'h1);
      check("hit_stall",       {31'b0, stall}, 32'h0);
      check("hit_mem_read",    {31'b0, mem_read}, 32'h0);
      tick();

      // Miss at 0x104, ack in the third wait cycle, then refetch hits.
      set_fetch(32'h104, 32'h104, 1'b1);
      exp_q.push_back(32'h00112023);
      exp_q.push_back(32'h00112023);
      #1;
      check("miss_stall_idle", {31'b0, stall}, 32'h1);
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'h00112023; end
         #1;
         check("miss_mem_read", {31'b0, mem_read}, 32'h1);
         check("miss_mem_addr", mem_addr, 32'h104);
         check("miss_stall",    {31'b0, stall}, 32'h1);
      end
      tick();
      mem_ack = 1'b0; mem_rdata = '0;
      #1;
      check("dfill_cache_fill", {31'b0, cache_fill}, 32'h1);
      check("dfill_fill_instr", fill_instruction, 32'h00112023);
      check("dfill_cache_addr", cache_addr, 32'h104);
      check("dfill_valid",      {31'b0, instr_valid}, 32'h1);
      check("dfill_mem_read",   {31'b0, mem_read}, 32'h0);
      tick();
      #1;
      check("refetch_hit_valid", {31'b0, instr_valid}, 32'h1);
      check("refetch_mem_read",  {31'b0, mem_read}, 32'h0);
      tick();

      // Zero word at 0x200: delivered, never cached, so it misses again.
      set_fetch(32'h200, 32'h200, 1'b1);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      tick();
      mem_ack = 1'b1; mem_rdata = 32'h0;
      #1;
      check("zero_mem_addr", mem_addr, 32'h200);
      tick();
      mem_ack = 1'b0;
      #1;
      check("zero_valid",     {31'b0, instr_valid}, 32'h1);
      check("zero_instr_out", instr_out, 32'h0);
      tick();
      #1;
      check("zero_remiss_stall", {31'b0, stall}, 32'h1);
      tick();
      mem_ack = 1'b1; mem_rdata = 32'h0;
      #1;
      check("zero_reissue_read", {31'b0, mem_read}, 32'h1);
      check("zero_reissue_addr", mem_addr, 32'h200);
      tick();
      mem_ack = 1'b0;
      tick();
      fetch_req = 1'b0;

      // Prefetch of 0x108, demand for it arrives during P_WAIT.
      set_fetch(32'h104, 32'h108, 1'b0);
      exp_q.push_back(32'h00000513);
      exp_q.push_back(32'h00000513);
      #1;
      check("pf_idle_mem_read", {31'b0, mem_read}, 32'h0);
      tick();
      set_fetch(32'h108, 32'h108, 1'b1);
      #1;
      check("pf_mem_read",    {31'b0, mem_read}, 32'h1);
      check("pf_mem_addr",    mem_addr, 32'h108);
      check("pf_demand_stall", {31'b0, stall}, 32'h1);
      check("pf_wait_valid",  {31'b0, instr_valid}, 32'h0);
      mem_ack = 1'b1; mem_rdata = 32'h00000513;
      tick();
      mem_ack = 1'b0; mem_rdata = '0;
      #1;
      check("pfill_cache_fill", {31'b0, cache_fill}, 32'h1);
      check("pfill_cache_addr", cache_addr, 32'h108);
      check("pfill_instr_out",  instr_out, 32'h00000513);
      check("pfill_stall",      {31'b0, stall}, 32'h0);
      check("pfill_mem_read",   {31'b0, mem_read}, 32'h0);
      tick();
      #1;
      check("pf_after_hit", {31'b0, instr_valid}, 32'h1);
      tick();
      fetch_req = 1'b0;

      // Demand timeout at 0x300.
      set_fetch(32'h300, 32'h300, 1'b1);
      #1;
      check("to_idle_stall", {31'b0, stall}, 32'h1);
      tick();
      n_rd = 0; n_fill = 0;
      for (int i = 0; i < 100; i++) begin
         if (!mem_read) break;
         n_rd++;
         if (cache_fill || fetch_error) n_fill++;
         tick();
      end
      check("to_read_cycles",   n_rd, 32'd64);
      check("to_early_events",  n_fill, 32'd0);
      check("to_fetch_error",   {31'b0, fetch_error}, 32'h1);
      check("to_stall",         {31'b0, stall}, 32'h0);
      check("to_valid",         {31'b0, instr_valid}, 32'h0);
      check("to_cache_fill",    {31'b0, cache_fill}, 32'h0);
      fetch_req = 1'b0;
      tick();
      check("to_error_pulse",   {31'b0, fetch_error}, 32'h0);
      check("to_after_read",    {31'b0, mem_read}, 32'h0);

      // Reset while a demand read is outstanding; late ack is ignored.
      set_fetch(32'h400, 32'h400, 1'b1);
      tick();
      check("rm_mem_read", {31'b0, mem_read}, 32'h1);
      rst = 1'b1;
      #1;
      check("rm_async_read", {31'b0, mem_read}, 32'h0);
      check("rm_state",      32'(state_dbg), 32'(IDLE));
      fetch_req = 1'b0;
      tick();
      rst = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
      #1;
      check("rm_ack_fill",  {31'b0, cache_fill}, 32'h0);
      check("rm_ack_valid", {31'b0, instr_valid}, 32'h0);
      tick();
      mem_ack = 1'b0; mem_rdata = '0;
      #1;
      check("rm_post_fill",  {31'b0, cache_fill}, 32'h0);
      check("rm_post_read",  {31'b0, mem_read}, 32'h0);
      check("rm_post_state", 32'(state_dbg), 32'(IDLE));
      tick();

      check("sb_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
